// File: rtl/id_dispatch_ctrl.sv
// rtl/id_dispatch_ctrl.sv - ID queue to ALU/MEM/BR issue-queue dispatcher with credit flow control.
// One entry per cycle leaves the FWFT ID queue head; class 3 entries are popped and dropped.
module id_dispatch_ctrl #(
  parameter int ENTRY_W   = 96,
  parameter int CLASS_LSB = 94,
  parameter int CREDITS   = 4,
  parameter int CNT_W     = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               FREEZE,
  input  logic               mispredict,
  input  logic               flush_fCOM,
  input  logic               idq_empty,
  input  logic [ENTRY_W-1:0] idq_data,
  output logic               idq_do_read,
  input  logic               ret_alu,
  input  logic               ret_mem,
  input  logic               ret_br,
  output logic [ENTRY_W-1:0] out_data,
  output logic               out_vld_alu,
  output logic               out_vld_mem,
  output logic               out_vld_br,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   disp_cnt,
  output logic               credit_err
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [2:0] CRED_MAX = 3'(CREDITS);

  logic [1:0]         state_q, state_d;
  logic [2:0]         cred_alu_q, cred_alu_d;
  logic [2:0]         cred_mem_q, cred_mem_d;
  logic [2:0]         cred_br_q, cred_br_d;
  logic [ENTRY_W-1:0] out_data_q, out_data_d;
  logic               vld_alu_q, vld_alu_d;
  logic               vld_mem_q, vld_mem_d;
  logic               vld_br_q, vld_br_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   disp_cnt_q, disp_cnt_d;
  logic               err_q, err_d;

  logic       flush;
  logic [1:0] cls;
  logic       ok;
  logic       pop;
  logic       dispatch;
  logic       cons_alu, cons_mem, cons_br;
  logic       e_alu, e_mem, e_br;

  // Returns {overflow, next credit}; a return into a full counter is held and flagged.
  function automatic logic [3:0] cred_next(input logic [2:0] cred, input logic cons, input logic ret);
    if (ret && !cons && cred == CRED_MAX) begin
      cred_next = {1'b1, cred};
    end else begin
      cred_next = {1'b0, cred - 3'(cons) + 3'(ret)};
    end
  endfunction

  assign flush = mispredict | flush_fCOM;
  assign cls   = idq_data[CLASS_LSB+1:CLASS_LSB];

  always_comb begin
    ok = 1'b1;
    case (cls)
      2'd0:    ok = (cred_alu_q != 3'd0);
      2'd1:    ok = (cred_mem_q != 3'd0);
      2'd2:    ok = (cred_br_q != 3'd0);
      default: ok = 1'b1;
    endcase
  end

  assign pop         = (state_q == ST_RUN) && !FREEZE && !flush && !idq_empty && ok;
  assign idq_do_read = pop;
  assign dispatch    = pop && (cls != 2'd3);
  assign cons_alu    = dispatch && (cls == 2'd0);
  assign cons_mem    = dispatch && (cls == 2'd1);
  assign cons_br     = dispatch && (cls == 2'd2);

  always_comb begin
    state_d     = state_q;
    cred_alu_d  = cred_alu_q;
    cred_mem_d  = cred_mem_q;
    cred_br_d   = cred_br_q;
    out_data_d  = out_data_q;
    vld_alu_d   = vld_alu_q;
    vld_mem_d   = vld_mem_q;
    vld_br_d    = vld_br_q;
    stall_cnt_d = stall_cnt_q;
    disp_cnt_d  = disp_cnt_q;
    err_d       = err_q;
    e_alu       = 1'b0;
    e_mem       = 1'b0;
    e_br        = 1'b0;

    if (flush) begin
      state_d    = ST_FLUSH;
      cred_alu_d = CRED_MAX;
      cred_mem_d = CRED_MAX;
      cred_br_d  = CRED_MAX;
      vld_alu_d  = 1'b0;
      vld_mem_d  = 1'b0;
      vld_br_d   = 1'b0;
      if (state_q == ST_STALL && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else if (!FREEZE) begin
      {e_alu, cred_alu_d} = cred_next(cred_alu_q, cons_alu, ret_alu);
      {e_mem, cred_mem_d} = cred_next(cred_mem_q, cons_mem, ret_mem);
      {e_br, cred_br_d}   = cred_next(cred_br_q, cons_br, ret_br);
      err_d     = err_q | e_alu | e_mem | e_br;
      vld_alu_d = cons_alu;
      vld_mem_d = cons_mem;
      vld_br_d  = cons_br;
      if (dispatch) begin
        out_data_d = idq_data;
        disp_cnt_d = disp_cnt_q + CNT_W'(1);
      end
      case (state_q)
        ST_RUN:   if (!idq_empty && !ok) state_d = ST_STALL;
        ST_STALL: if (idq_empty || ok) state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
      if (state_q == ST_STALL && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_RUN;
      cred_alu_q  <= CRED_MAX;
      cred_mem_q  <= CRED_MAX;
      cred_br_q   <= CRED_MAX;
      out_data_q  <= '0;
      vld_alu_q   <= 1'b0;
      vld_mem_q   <= 1'b0;
      vld_br_q    <= 1'b0;
      stall_cnt_q <= '0;
      disp_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cred_alu_q  <= cred_alu_d;
      cred_mem_q  <= cred_mem_d;
      cred_br_q   <= cred_br_d;
      out_data_q  <= out_data_d;
      vld_alu_q   <= vld_alu_d;
      vld_mem_q   <= vld_mem_d;
      vld_br_q    <= vld_br_d;
      stall_cnt_q <= stall_cnt_d;
      disp_cnt_q  <= disp_cnt_d;
      err_q       <= err_d;
    end
  end

  // A strobe pending when FREEZE rises is held and delivered once the issue stage thaws.
  assign out_vld_alu = vld_alu_q & ~FREEZE;
  assign out_vld_mem = vld_mem_q & ~FREEZE;
  assign out_vld_br  = vld_br_q & ~FREEZE;
  assign out_data    = out_data_q;
  assign stall_cnt   = stall_cnt_q;
  assign disp_cnt    = disp_cnt_q;
  assign credit_err  = err_q;

endmodule
